seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle 32-bit integer divider for the kgp_risc ALU: the subtract-based counterpart to the combinational 32-bit adder.
- Performs restoring shift-subtract division, one quotient bit per clock.
- Sits beside the ALU; the control unit launches it with a start pulse and stalls until done.
- Supports signed and unsigned operands.

Parameters:
- WIDTH, 32, operand/result width in bits (design and verification at 32 only).
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request, sampled only in IDLE.
- is_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
- dividend  input  32  numerator; sampled with start.
- divisor  input  32  denominator; sampled with start.
- busy  output  1  high from the edge that accepts start until done.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  32  result quotient; held until the next accepted start.
- remainder  output  32  result remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held until the next accepted start.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; internal registers and counter cleared. This applies mid-operation too: the computation is abandoned and no done is issued.
- States: IDLE, RUN, FIX.
- IDLE: on an edge with start=1, accept the operation at edge k:
  - latch the operand signs;
  - load |dividend| and |divisor|; absolute value is applied only if is_signed=1, and |0x80000000| is taken as 0x80000000 unsigned;
  - clear the 33-bit partial remainder; count=0; busy=1.
  - If divisor==0, go directly to FIX with the zero flag set. Otherwise go to RUN.
- RUN, edges k+1..k+32, one iteration per edge:
  - shift {partial remainder, dividend register} left by 1;
  - trial = partial - {0, divisor} (33-bit);
  - if trial is non-negative, partial=trial and the quotient LSB is 1; else keep partial and the LSB is 0;
  - count++. After the 32nd iteration go to FIX.
- FIX, one edge (k+33; k+1 for divide-by-zero):
  - Signed: negate the quotient if sign(dividend)^sign(divisor); negate the remainder if sign(dividend). The remainder takes the sign of the dividend, with truncation toward zero.
  - Register the outputs; done=1 for exactly one cycle; busy=0 on the same edge; return to IDLE.
- Latency: start accepted at edge k gives done visible after edge k+33 (34 cycles). Divide-by-zero gives done after edge k+1.
- Divide-by-zero results: quotient=0xFFFFFFFF, remainder=dividend (raw input value), div_by_zero=1, for both signed and unsigned.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, with no special flag; this falls out naturally.
- start while busy: ignored, with no effect on the in-flight operation. start is accepted in the cycle after done, because the state is already IDLE.
- Operand inputs are don't-care except on the accepting edge.
- Outputs change only in FIX or on reset.

Decomposition:
- Shared package kgp_risc_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIX=2'd2;
  - DIV_ITER=32;
  - DIV0_QUOT=32'hFFFFFFFF.
- One sub-module, div_sub_step: combinational 33-bit trial subtract that returns the next partial remainder and the quotient bit.
- Control FSM and negation logic stay in seq_divider.

Test Plan:
- Unsigned 100/7, is_signed=0, start at edge k -> busy high from k, done pulse after edge k+33, quotient=14, remainder=2, div_by_zero=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Divisor 0, dividend 0x12345678 -> done after edge k+1, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. A following normal 9/3 clears div_by_zero and gives quotient=3, remainder=0.
- Edge values:
  - unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0;
  - signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0;
  - unsigned 5/9 -> quotient=0, remainder=5.
- start re-pulsed with different operands at edge k+10 of 100/7 -> ignored, result still 14/2 at k+33. A back-to-back start in the done cycle is accepted.
- rst_n driven low at edge k+15 of a run -> busy, done and outputs clear immediately (async) and no done occurs. After release, a new 50/5 run gives quotient=10, remainder=0.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared kgp_risc constants for the divider: state encoding, iteration count, div-by-zero quotient.
// Pure declarations; no timing or flow-control behaviour of its own.
package kgp_risc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam int          DIV_ITER  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIX  = ST_FIX
  } div_state_t;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
// Purely combinational, zero latency; no flow control.
module div_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] part_nx,
  output logic             qbit
);

  logic [WIDTH:0] trial;

  // shifted < 2*divisor, so bit WIDTH of the 33-bit difference is a valid sign bit
  always_comb begin
    trial   = shifted - {1'b0, divisor};
    qbit    = ~trial[WIDTH];
    part_nx = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per clock; done 34 cycles after start (2 on div-by-zero).
// No backpressure: start is only sampled in IDLE and ignored while busy; results are held until the next accepted start.
module seq_divider
  import kgp_risc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  // The remainder never exceeds the divisor, so WIDTH bits hold it; the 33rd bit lives only in the step.
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] dreg;
  logic [WIDTH-1:0] dvs;
  logic             neg_q, neg_r, dz;

  logic [WIDTH-1:0] a_abs, b_abs, part_nx;
  logic             qbit;
  logic             div0_in;

  always_comb begin
    a_abs   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    b_abs   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    div0_in = (divisor == '0);
  end

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .shifted (({part, dreg[WIDTH-1]})),
    .divisor (dvs),
    .part_nx (part_nx),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = div0_in ? S_FIX : S_RUN;
      S_RUN:   if (cnt == CNT_W'(DIV_ITER - 1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      part        <= '0;
      dreg        <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= is_signed & dividend[WIDTH-1];
            dz    <= div0_in;
            dvs   <= b_abs;
            // on divide-by-zero the raw dividend is parked here to become the remainder
            dreg  <= div0_in ? dividend : a_abs;
            part  <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          part <= part_nx;
          dreg <= {dreg[WIDTH-2:0], qbit};
          cnt  <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dz;
          if (dz) begin
            quotient  <= WIDTH'(DIV0_QUOT);
            remainder <= dreg;
          end else begin
            quotient  <= neg_q ? -dreg : dreg;
            remainder <= neg_r ? -part : part;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus random checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder signed like the dividend
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, q64, r64;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q64 = sa / sb;
      r64 = sa % sb;
      q = q64[31:0]; r = r64[31:0]; z = 1'b0;
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    chk("busy_at_accept", 32'(busy), 32'd1);
    chk("done_low_at_accept", 32'(done), 32'd0);
    chk("quotient_held", quotient, prev_q);
  endtask

  // rp > 0 re-pulses start with junk operands at accept edge + rp
  task automatic wait_done(input logic [31:0] a, input logic [31:0] b, input logic s, input int rp);
    logic [31:0] eq, er;
    logic        ez;
    int          n;
    logic        got;
    model(a, b, s, eq, er, ez);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); n++; #1;
      if (rp != 0 && n == rp - 1) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom_range(1, 9); is_signed = ~s;
      end
      if (rp != 0 && n == rp) start = 1'b0;
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(n), (b == 0) ? 32'd1 : 32'd33);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    chk("busy_at_done", 32'(busy), 32'd0);
    prev_q = eq; prev_r = er;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s);
    launch(a, b, s);
    wait_done(a, b, s, 0);
  endtask

  initial begin
    logic        saw;
    logic [31:0] ra, rb;
    logic        rs;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    op(32'd100, 32'd7, 1'b0);
    op(32'hFFFF_FFF9, 32'd2, 1'b1);
    op(32'd7, 32'hFFFF_FFFE, 1'b1);
    op(32'h1234_5678, 32'd0, 1'b0);
    op(32'd9, 32'd3, 1'b0);
    op(32'hFFFF_FFFF, 32'd1, 1'b0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    op(32'd5, 32'd9, 1'b0);
    op(32'hDEAD_BEEF, 32'd0, 1'b1);

    // Start re-pulsed mid-run must be ignored
    launch(32'd100, 32'd7, 1'b0);
    wait_done(32'd100, 32'd7, 1'b0, 10);

    // Idle gap, then asynchronous reset in the middle of a run
    repeat (3) @(posedge clk);
    launch(32'd1000, 32'd3, 1'b0);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
    prev_q = '0; prev_r = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    chk("no_done_after_reset", 32'(saw), 32'd0);
    op(32'd50, 32'd5, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 7 == 3)      rb = 32'd0;
      else if (i % 4 == 0) rb = $urandom_range(1, 15);
      else if (i % 4 == 1) rb = -($urandom_range(1, 15));
      else                 rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0 && i % 7 != 3) rb = 32'd1;
      op(ra, rb, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
